// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory port arbiter.
// RD_LATENCY follows the MEM_ARB_OUT_REG_EN build macro.
package mem_arb_pkg;

`ifdef MEM_ARB_OUT_REG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

  // Upper bound on requesters the one-hot helpers can represent.
  localparam int MAX_PORTS = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input int idx);
    logic [MAX_PORTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after the priority pointer wins.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int PORTS = 4,
  localparam int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [PORTS-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  always_comb begin
    int cand;
    // NOTE: defaults first so every path assigns every output; no latch.
    valid = 1'b0;
    index = '0;
    cand  = 0;
    // Walk from the farthest candidate back to the pointer so the nearest one wins.
    for (int off = PORTS - 1; off >= 0; off--) begin
      cand = (int'(pointer) + off) % PORTS;
      if (req[cand]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
    grant = valid ? PORTS'(idx_to_onehot(int'(index))) : '0;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read memory port among PORTS requesters, round-robin.
// Build macro MEM_ARB_OUT_REG_EN adds a register stage on mem_dout (RD_LATENCY=2).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int BYTES_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 13,
  parameter int LINE_SIZE      = 8 * BYTES_PER_LINE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               req_valid,
  output logic [PORTS-1:0]               req_ready,
  input  logic [PORTS*ADDR_WIDTH-1:0]    req_addr,
  input  logic [PORTS*BYTES_PER_LINE-1:0] req_wen,
  input  logic [PORTS*LINE_SIZE-1:0]     req_din,
  output logic [PORTS-1:0]               resp_valid,
  output logic [LINE_SIZE-1:0]           resp_data,
  output logic                           mem_en,
  output logic [BYTES_PER_LINE-1:0]      mem_wen,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [LINE_SIZE-1:0]           mem_din,
  input  logic [LINE_SIZE-1:0]           mem_dout
);

  localparam int IDX_W = idx_width(PORTS);

  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          gnt_idx;
  logic [PORTS-1:0]          gnt_oh;
  logic                      gnt_valid;
  logic                      grant_fire;
  logic                      rd_fire;
  logic [BYTES_PER_LINE-1:0] sel_wen;

  rr_arbiter #(.PORTS(PORTS)) u_rr (
    .req     (req_valid),
    .pointer (ptr),
    .grant   (gnt_oh),
    .index   (gnt_idx),
    .valid   (gnt_valid)
  );

  // Reset masks the grant in the same cycle so nothing reaches memory during rst.
  assign grant_fire = gnt_valid & ~rst;
  assign req_ready  = rst ? '0 : gnt_oh;
  assign sel_wen    = req_wen[int'(gnt_idx)*BYTES_PER_LINE +: BYTES_PER_LINE];
  assign rd_fire    = grant_fire & (sel_wen == '0);

  assign mem_en   = grant_fire;
  assign mem_wen  = grant_fire ? sel_wen : '0;
  assign mem_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_din  = req_din[int'(gnt_idx)*LINE_SIZE +: LINE_SIZE];

  // NOTE: non-blocking assignments for all flop updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (int'(gnt_idx) == PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Read-tag pipeline: one stage per cycle of read latency.
  logic [RD_LATENCY-1:0] tag_vld;
  logic [IDX_W-1:0]      tag_idx [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= rd_fire;
      for (int s = 1; s < RD_LATENCY; s++) tag_vld[s] <= tag_vld[s-1];
    end
  end

  // NOTE: the index payload needs no reset; tag_vld alone qualifies it.
  always_ff @(posedge clk) begin
    tag_idx[0] <= gnt_idx;
    for (int s = 1; s < RD_LATENCY; s++) tag_idx[s] <= tag_idx[s-1];
  end

  assign resp_valid = (rst || !tag_vld[RD_LATENCY-1]) ? '0
                    : PORTS'(idx_to_onehot(int'(tag_idx[RD_LATENCY-1])));

  logic [LINE_SIZE-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (tag_vld[0]) begin
      data_q <= mem_dout;
    end
  end

`ifdef MEM_ARB_OUT_REG_EN
  assign resp_data = rst ? '0 : data_q;
`else
  // Pass mem_dout straight through on a response; otherwise hold the last value.
  assign resp_data = rst ? '0 : (tag_vld[0] ? mem_dout : data_q);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand sequences, read responses
// checked through a scoreboard against a behavioural registered-read memory.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_ready;
  logic [51:0]   req_addr = '0;
  logic [15:0]   req_wen = '0;
  logic [127:0]  req_din = '0;
  logic [3:0]    resp_valid;
  logic [31:0]   resp_data;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [12:0]   mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = '0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wen    (req_wen),
    .req_din    (req_din),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mem_en     (mem_en),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [12:0] a);
    return {3'b101, a, 3'b010, a};
  endfunction

  // Behavioural memory: byte-enabled writes, read data registered one cycle.
  logic [31:0] mem_model [8192];
  logic [31:0] shadow [8192];

  initial begin
    for (int a = 0; a < 8192; a++) begin
      mem_model[a] = init_val(13'(a));
      shadow[a]    = init_val(13'(a));
    end
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen == 4'b0000) mem_dout <= mem_model[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem_model[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  typedef struct {
    logic [3:0]  vec;
    logic [31:0] data;
    int          due;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] last_data = '0;

  // Response monitor: every cycle either a due response or an idle, held output.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst) begin
      sbq.delete();
      last_data = '0;
      check("rst_resp_valid", 128'(resp_valid), 128'(4'b0000));
      check("rst_resp_data", 128'(resp_data), 128'(32'h0));
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check("resp_valid", 128'(resp_valid), 128'(e.vec));
      check("resp_data", 128'(resp_data), 128'(e.data));
      last_data = e.data;
    end else begin
      check("idle_resp_valid", 128'(resp_valid), 128'(4'b0000));
      check("resp_data_hold", 128'(resp_data), 128'(last_data));
    end
  end

  logic [12:0] pa [4];
  logic [3:0]  pw [4];
  logic [31:0] pd [4];

  task automatic drive(input logic [3:0] v, input logic [3:0] exp_rdy, input bit rst_v,
                       input bit want_resp, input bit use_fdata, input logic [31:0] fdata);
    int  g;
    sb_t e;
    @(posedge clk);
    #1;
    rst       = rst_v;
    req_valid = v;
    for (int p = 0; p < 4; p++) begin
      req_addr[p*13 +: 13] = pa[p];
      req_wen[p*4 +: 4]    = pw[p];
      req_din[p*32 +: 32]  = pd[p];
    end
    @(negedge clk);
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    check("mem_en", 128'(mem_en), 128'(|exp_rdy));
    g = -1;
    for (int p = 0; p < 4; p++) if (exp_rdy[p]) g = p;
    if (g < 0) begin
      check("mem_wen_idle", 128'(mem_wen), 128'(4'b0000));
    end else begin
      check("mem_addr", 128'(mem_addr), 128'(pa[g]));
      check("mem_wen", 128'(mem_wen), 128'(pw[g]));
      check("mem_din", 128'(mem_din), 128'(pd[g]));
      if (pw[g] == 4'b0000) begin
        if (want_resp) begin
          e.vec  = exp_rdy;
          e.data = use_fdata ? fdata : shadow[pa[g]];
          e.due  = cyc + LAT;
          sbq.push_back(e);
        end
      end else begin
        for (int b = 0; b < 4; b++)
          if (pw[g][b]) shadow[pa[g]][b*8 +: 8] = pd[g][b*8 +: 8];
      end
    end
  endtask

  task automatic set_port(input int p, input logic [12:0] a, input logic [3:0] w, input logic [31:0] d);
    pa[p] = a;
    pw[p] = w;
    pd[p] = d;
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] wr;
    logic [3:0] rdy;
  } vec_t;

  vec_t tbl [14];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Pointer starts at 0 after reset; each row's expected grant follows round-robin.
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1001, 4'b0000, 4'b1000};
    tbl[7]  = '{4'b1001, 4'b0000, 4'b0001};
    tbl[8]  = '{4'b0101, 4'b0100, 4'b0100};
    tbl[9]  = '{4'b0101, 4'b0000, 4'b0001};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0001};
    tbl[11] = '{4'b1110, 4'b1000, 4'b0010};
    tbl[12] = '{4'b1100, 4'b0000, 4'b0100};
    tbl[13] = '{4'b1000, 4'b1000, 4'b1000};

    for (int p = 0; p < 4; p++) set_port(p, 13'h0, 4'h0, 32'h0);

    // Reset with all ports requesting: no grant may leak out.
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);

    for (int r = 0; r < 14; r++) begin
      for (int p = 0; p < 4; p++)
        set_port(p, 13'(13'h100 + r*4 + p), tbl[r].wr[p] ? (4'hF ^ 4'(1 << p)) : 4'h0,
                 32'hC0DE0000 | 32'(r << 8) | 32'(p));
      drive(tbl[r].v, tbl[r].rdy, 1'b0, 1'b1, 1'b0, 32'h0);
    end

    // Full-line write then read from another port.
    set_port(2, 13'h010, 4'hF, 32'hDEADBEEF);
    drive(4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 32'h0);
    set_port(1, 13'h010, 4'h0, 32'h0);
    drive(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF);

    // Single-byte write merges into the existing line.
    set_port(3, 13'h010, 4'b0010, 32'h0000AA00);
    drive(4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 32'hDEADAAEF);

    // Lone requester is granted every cycle; pointer ends just past it.
    for (int i = 0; i < 5; i++) begin
      set_port(1, 13'(13'h020 + i), 4'h0, 32'h0);
      drive(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    for (int p = 0; p < 4; p++) set_port(p, 13'(13'h040 + p), 4'h0, 32'h0);
    drive(4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset right after that read grant drops the response and resets the pointer.
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 4; i++) drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0);
    check("scoreboard_drained", 128'(sbq.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
